weight_loader: RTL and testbench

WEIGHT_LOADER -- requirements
Module: weight_loader

---
 rtl/loader_pkg.sv | 13 +
 rtl/weight_loader.sv | 196 +++++++++++++++++++
 tb/tb_weight_loader.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared state encoding and word width for the weight loader
package loader_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WEIGHTS = 2'd1,
        ST_BIAS    = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

endpackage

// File: rtl/weight_loader.sv
// rtl/weight_loader.sv - streams per-neuron weights (and bias when LOADER_BIAS_EN is defined) to a layer
module weight_loader
    import loader_pkg::*;
#(
    parameter int numWeight  = 784,
    parameter int numNeurons = 30,
    parameter int dataWidth  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WORD_W-1:0] cfg_layer,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              weightValid,
    output logic              biasValid,
    output logic [WORD_W-1:0] weightValue,
    output logic [WORD_W-1:0] biasValue,
    output logic [WORD_W-1:0] config_layer_num,
    output logic [WORD_W-1:0] config_neuron_num,
    output logic              busy,
    output logic              done
);

    // A single weight or neuron still needs a one-bit counter, so never let the width reach zero.
    localparam int WCNT_W = (numWeight  > 1) ? $clog2(numWeight)  : 1;
    localparam int NCNT_W = (numNeurons > 1) ? $clog2(numNeurons) : 1;
    localparam logic [WCNT_W-1:0] LAST_WORD   = WCNT_W'(numWeight - 1);
    localparam logic [NCNT_W-1:0] LAST_NEURON = NCNT_W'(numNeurons - 1);

    state_t              r_state;
    state_t              w_next;
    logic [WCNT_W-1:0]   r_word;
    logic [NCNT_W-1:0]   r_neuron;
    logic                w_xfer;
    logic                w_last_word;
    logic                w_last_neuron;
    logic [WORD_W-1:0]   w_word;

    assign w_xfer        = s_valid & s_ready;
    assign w_last_word   = (r_word == LAST_WORD);
    assign w_last_neuron = (r_neuron == LAST_NEURON);

    // Significant low bits and the untouched upper bits are reassembled into the outgoing word.
    generate
        if (dataWidth < WORD_W) begin : g_split
            assign w_word = {s_data[WORD_W-1:dataWidth], s_data[dataWidth-1:0]};
        end else begin : g_full
            assign w_word = s_data;
        end
    endgenerate

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; start is only honoured from IDLE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next = ST_WEIGHTS;
                end
            end
            ST_WEIGHTS: begin
                if (w_xfer && w_last_word) begin
`ifdef LOADER_BIAS_EN
                    w_next = ST_BIAS;
`else
                    w_next = w_last_neuron ? ST_DONE : ST_WEIGHTS;
`endif
                end
            end
`ifdef LOADER_BIAS_EN
            ST_BIAS: begin
                if (w_xfer) begin
                    w_next = w_last_neuron ? ST_DONE : ST_WEIGHTS;
                end
            end
`endif
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // State-decoded handshake and status outputs.
    always_comb begin
        s_ready = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (r_state)
            ST_WEIGHTS, ST_BIAS: begin
                s_ready = 1'b1;
                busy    = 1'b1;
            end
            ST_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Word and neuron counters; they only move on an accepted transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_word   <= '0;
            r_neuron <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_word   <= '0;
                        r_neuron <= '0;
                    end
                end
                ST_WEIGHTS: begin
                    if (w_xfer) begin
                        if (w_last_word) begin
                            r_word <= '0;
`ifndef LOADER_BIAS_EN
                            if (!w_last_neuron) begin
                                r_neuron <= r_neuron + NCNT_W'(1);
                            end
`endif
                        end else begin
                            r_word <= r_word + WCNT_W'(1);
                        end
                    end
                end
`ifdef LOADER_BIAS_EN
                ST_BIAS: begin
                    if (w_xfer && !w_last_neuron) begin
                        r_neuron <= r_neuron + NCNT_W'(1);
                    end
                end
`endif
                default: begin
                end
            endcase
        end
    end

    // Output data registers: each pulse carries the neuron number captured with its own transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            weightValid       <= 1'b0;
            weightValue       <= '0;
            config_layer_num  <= '0;
            config_neuron_num <= '0;
`ifdef LOADER_BIAS_EN
            biasValid         <= 1'b0;
            biasValue         <= '0;
`endif
        end else begin
            weightValid <= 1'b0;
`ifdef LOADER_BIAS_EN
            biasValid   <= 1'b0;
`endif
            if (r_state == ST_IDLE && start) begin
                config_layer_num  <= cfg_layer;
                config_neuron_num <= '0;
            end
            if (r_state == ST_WEIGHTS && w_xfer) begin
                weightValid       <= 1'b1;
                weightValue       <= w_word;
                config_neuron_num <= WORD_W'(r_neuron);
            end
`ifdef LOADER_BIAS_EN
            if (r_state == ST_BIAS && w_xfer) begin
                biasValid         <= 1'b1;
                biasValue         <= w_word;
                config_neuron_num <= WORD_W'(r_neuron);
            end
`endif
        end
    end

`ifndef LOADER_BIAS_EN
    assign biasValid = 1'b0;
    assign biasValue = '0;
`endif

endmodule

// File: tb/tb_weight_loader.sv
// tb/tb_weight_loader.sv - directed self-checking bench for weight_loader (LOADER_BIAS_EN aware)
module tb_weight_loader;

    logic        clk = 1'b0;
    logic        rst;

    logic        a_start, a_valid, a_ready, a_wv, a_bv, a_busy, a_done;
    logic [31:0] a_cfg, a_data, a_wval, a_bval, a_lay, a_neu;
    logic        b_start, b_valid, b_ready, b_wv, b_bv, b_busy, b_done;
    logic [31:0] b_cfg, b_data, b_wval, b_bval, b_lay, b_neu;

    int n_cmp  = 0;
    int n_fail = 0;
    int obs[$];
    int exp_q[$];

`ifdef LOADER_BIAS_EN
    localparam int FULL_WORDS = 10;
    localparam int PART_WORDS = 8;
`else
    localparam int FULL_WORDS = 8;
    localparam int PART_WORDS = 7;
`endif

    always #5 clk = ~clk;

    weight_loader #(.numWeight(4), .numNeurons(2), .dataWidth(16)) u_a (
        .clk(clk), .rst(rst), .start(a_start), .cfg_layer(a_cfg),
        .s_data(a_data), .s_valid(a_valid), .s_ready(a_ready),
        .weightValid(a_wv), .biasValid(a_bv), .weightValue(a_wval), .biasValue(a_bval),
        .config_layer_num(a_lay), .config_neuron_num(a_neu), .busy(a_busy), .done(a_done)
    );

    weight_loader #(.numWeight(1), .numNeurons(1), .dataWidth(16)) u_b (
        .clk(clk), .rst(rst), .start(b_start), .cfg_layer(b_cfg),
        .s_data(b_data), .s_valid(b_valid), .s_ready(b_ready),
        .weightValid(b_wv), .biasValid(b_bv), .weightValue(b_wval), .biasValue(b_bval),
        .config_layer_num(b_lay), .config_neuron_num(b_neu), .busy(b_busy), .done(b_done)
    );

    // Pulse code: kind*1e6 + layer*1e4 + neuron*100 + value; +1e8 if no transfer preceded it.
    function automatic int enc(input int kind, input logic [31:0] lay, input logic [31:0] neu,
                               input logic [31:0] val, input bit orphan);
        return kind * 1000000 + int'(lay % 100) * 10000 + int'(neu % 100) * 100
             + int'(val % 100) + (orphan ? 100000000 : 0);
    endfunction

    function automatic void build_full();
        exp_q.delete();
        for (int n = 0; n < 2; n++) begin
`ifdef LOADER_BIAS_EN
            for (int w = 0; w < 4; w++) exp_q.push_back(1010000 + 100 * n + n * 5 + w + 1);
            exp_q.push_back(2010000 + 100 * n + n * 5 + 5);
`else
            for (int w = 0; w < 4; w++) exp_q.push_back(1010000 + 100 * n + n * 4 + w + 1);
`endif
        end
        exp_q.push_back(3000000);
    endfunction

    task automatic do_start(input bit sel);
        if (sel) begin b_cfg = 32'd1; b_start = 1'b1; end
        else     begin a_cfg = 32'd1; a_start = 1'b1; end
        @(posedge clk); #1;
        a_start = 1'b0;
        b_start = 1'b0;
    endtask

    // Feeds words, records every output pulse; stops on done or after nwords transfers.
    task automatic run(input bit sel, input int nwords, input bit toggle, input int start_at,
                       input bit want_done, output bit timed_out);
        int idx;
        int cyc;
        bit x;
        bit v;
        bit fin;
        idx = 0; cyc = 0; fin = 0; timed_out = 0;
        obs.delete();
        while (!fin) begin
            if (cyc >= 200) begin
                timed_out = 1;
                break;
            end
            v = (idx < nwords) && (!toggle || (cyc % 2 == 0));
            if (sel) begin
                b_valid = v; b_data = 32'(7 + 2 * idx); x = v && b_ready;
            end else begin
                a_valid = v; a_data = 32'(idx + 1); x = v && a_ready;
                if (cyc == start_at) begin a_start = 1'b1; a_cfg = 32'd5; end
            end
            @(posedge clk); #1;
            a_start = 1'b0;
            if (x) idx++;
            if (sel) begin
                if (b_wv) obs.push_back(enc(1, b_lay, b_neu, b_wval, !x));
                if (b_bv) obs.push_back(enc(2, b_lay, b_neu, b_bval, !x));
                if (b_done) begin obs.push_back(3000000); if (want_done) fin = 1; end
            end else begin
                if (a_wv) obs.push_back(enc(1, a_lay, a_neu, a_wval, !x));
                if (a_bv) obs.push_back(enc(2, a_lay, a_neu, a_bval, !x));
                if (a_done) begin obs.push_back(3000000); if (want_done) fin = 1; end
            end
            if (!want_done && idx == nwords) fin = 1;
            cyc++;
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        a_cfg   = 32'd1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_start = 0; a_valid = 0; a_cfg = 32'd1; a_data = 0;
        b_start = 0; b_valid = 0; b_cfg = 32'd1; b_data = 0;
        #1;
        n_cmp++;
        if ({a_ready, a_wv, a_bv, a_busy, a_done} !== 5'b0) begin
            n_fail++; $display("FAIL reset_ctl_a got=%b need=00000", {a_ready, a_wv, a_bv, a_busy, a_done});
        end
        n_cmp++;
        if ({a_wval, a_bval, a_lay, a_neu} !== 128'd0) begin
            n_fail++; $display("FAIL reset_data_a got=%h need=0", {a_wval, a_bval, a_lay, a_neu});
        end
        n_cmp++;
        if ({b_ready, b_wv, b_bv, b_busy, b_done} !== 5'b0) begin
            n_fail++; $display("FAIL reset_ctl_b got=%b need=00000", {b_ready, b_wv, b_bv, b_busy, b_done});
        end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (a_ready !== 1'b0) begin
            n_fail++; $display("FAIL idle_ready got=%b need=0", a_ready);
        end
    endtask

    task automatic test_continuous();
        bit to;
        do_start(0);
        n_cmp++;
        if (a_busy !== 1'b1) begin n_fail++; $display("FAIL busy_after_start got=%b need=1", a_busy); end
        run(0, FULL_WORDS, 0, -1, 1, to);
        n_cmp++;
        if (to) begin n_fail++; $display("FAIL cont_timeout got=timeout need=done"); end
        build_full();
        n_cmp++;
        if (obs.size() != exp_q.size()) begin
            n_fail++; $display("FAIL cont_count got=%0d need=%0d", obs.size(), exp_q.size());
        end
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL cont_pulse[%0d] got=%0d need=%0d", i, obs[i], exp_q[i]);
            end
        end
        @(posedge clk); #1;
        n_cmp++;
        if ({a_busy, a_done} !== 2'b00) begin
            n_fail++; $display("FAIL cont_idle got=%b need=00", {a_busy, a_done});
        end
    endtask

    task automatic test_toggle();
        bit to;
        do_start(0);
        run(0, FULL_WORDS, 1, -1, 1, to);
        n_cmp++;
        if (to) begin n_fail++; $display("FAIL tog_timeout got=timeout need=done"); end
        build_full();
        n_cmp++;
        if (obs.size() != exp_q.size()) begin
            n_fail++; $display("FAIL tog_count got=%0d need=%0d", obs.size(), exp_q.size());
        end
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL tog_pulse[%0d] got=%0d need=%0d", i, obs[i], exp_q[i]);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_mid_reset();
        bit to;
        do_start(0);
        run(0, PART_WORDS, 0, -1, 0, to);
        n_cmp++;
        if (to) begin n_fail++; $display("FAIL mid_timeout got=timeout need=partial"); end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({a_ready, a_wv, a_bv, a_busy, a_done} !== 5'b0) begin
            n_fail++; $display("FAIL midrst_ctl got=%b need=00000", {a_ready, a_wv, a_bv, a_busy, a_done});
        end
        n_cmp++;
        if ({a_wval, a_bval, a_lay, a_neu} !== 128'd0) begin
            n_fail++; $display("FAIL midrst_data got=%h need=0", {a_wval, a_bval, a_lay, a_neu});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        do_start(0);
        run(0, FULL_WORDS, 0, -1, 1, to);
        build_full();
        n_cmp++;
        if (obs.size() != exp_q.size()) begin
            n_fail++; $display("FAIL reload_count got=%0d need=%0d", obs.size(), exp_q.size());
        end
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL reload_pulse[%0d] got=%0d need=%0d", i, obs[i], exp_q[i]);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_start_busy();
        bit to;
        do_start(0);
        run(0, FULL_WORDS, 0, 3, 1, to);
        build_full();
        n_cmp++;
        if (obs.size() != exp_q.size()) begin
            n_fail++; $display("FAIL busystart_count got=%0d need=%0d", obs.size(), exp_q.size());
        end
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL busystart_pulse[%0d] got=%0d need=%0d", i, obs[i], exp_q[i]);
            end
        end
        @(posedge clk); #1;
        n_cmp++;
        if (a_busy !== 1'b0) begin n_fail++; $display("FAIL busystart_idle got=%b need=0", a_busy); end
    endtask

    task automatic test_minimal();
        bit to;
        exp_q.delete();
        exp_q.push_back(1010007);
`ifdef LOADER_BIAS_EN
        exp_q.push_back(2010009);
        do_start(1);
        run(1, 2, 0, -1, 1, to);
`else
        do_start(1);
        run(1, 1, 0, -1, 1, to);
`endif
        exp_q.push_back(3000000);
        n_cmp++;
        if (to) begin n_fail++; $display("FAIL min_timeout got=timeout need=done"); end
        n_cmp++;
        if (obs.size() != exp_q.size()) begin
            n_fail++; $display("FAIL min_count got=%0d need=%0d", obs.size(), exp_q.size());
        end
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL min_pulse[%0d] got=%0d need=%0d", i, obs[i], exp_q[i]);
            end
        end
        @(posedge clk); #1;
        n_cmp++;
        if ({b_busy, b_done, b_ready} !== 3'b000) begin
            n_fail++; $display("FAIL min_idle got=%b need=000", {b_busy, b_done, b_ready});
        end
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_toggle();
        test_mid_reset();
        test_start_busy();
        test_minimal();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
